// File: rtl/usr_shift_sequencer.sv
// Control stage for a 4-bit universal shift register: loads a job word, issues
// the requested number of shifts, streams out the dropped bits, then holds.
module usr_shift_sequencer #(
    parameter int N  = 4,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_dir,
    input  logic [CW-1:0] in_amt,
    input  logic          in_fill,
    input  logic [N-1:0]  usr_q,
    output logic [1:0]    usr_s,
    output logic [N-1:0]  usr_i,
    output logic          usr_msb_in,
    output logic          usr_lsb_in,
    output logic          out_bit,
    output logic          out_valid,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

    state_t        state;
    logic [N-1:0]  job_data;
    logic          job_dir;
    logic          job_fill;
    logic [CW-1:0] job_amt;
    logic [CW-1:0] remaining;
    logic [CW-1:0] amt_clamped;
    logic [N-1:0]  drop_mask;

    always_comb begin
        amt_clamped = (in_amt > CW'(N)) ? CW'(N) : in_amt;
    end

    // Outputs are registered alongside the state, so each transition also
    // programs the outputs of the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            job_data  <= '0;
            job_dir   <= 1'b0;
            job_fill  <= 1'b0;
            job_amt   <= '0;
            remaining <= '0;
            usr_s     <= S_HOLD;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (in_valid) begin
                        job_data <= in_data;
                        job_dir  <= in_dir;
                        job_fill <= in_fill;
                        job_amt  <= amt_clamped;
                        state    <= LOAD;
                        usr_s    <= S_LOAD;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    remaining <= job_amt;
                    if (job_amt == '0) begin
                        state <= DONE;
                        usr_s <= S_HOLD;
                        done  <= 1'b1;
                    end else begin
                        state     <= SHIFT;
                        usr_s     <= job_dir ? S_LEFT : S_RIGHT;
                        out_valid <= 1'b1;
                    end
                end
                SHIFT: begin
                    remaining <= remaining - CW'(1);
                    if (remaining == CW'(1)) begin
                        state     <= DONE;
                        usr_s     <= S_HOLD;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    usr_s     <= S_HOLD;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Select the end of the register that drops a bit for the latched direction.
    always_comb begin
        drop_mask = job_dir ? {1'b1, {(N-1){1'b0}}} : {{(N-1){1'b0}}, 1'b1};
        out_bit   = out_valid & (|(usr_q & drop_mask));
    end

    assign in_ready   = (state == IDLE) & ~reset;
    assign usr_i      = job_data;
    assign usr_msb_in = job_fill & ~job_dir;
    assign usr_lsb_in = job_fill & job_dir;

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer with a USR attached; random and directed jobs
// checked cycle by cycle against a shift-arithmetic reference model.
module tb_usr_shift_sequencer;

    localparam int N  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic          in_dir;
    logic [CW-1:0] in_amt;
    logic          in_fill;
    logic [N-1:0]  usr_q;
    logic [1:0]    usr_s;
    logic [N-1:0]  usr_i;
    logic          usr_msb_in;
    logic          usr_lsb_in;
    logic          out_bit;
    logic          out_valid;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    logic [3:0] nxt_d;
    logic       nxt_dir;
    logic [2:0] nxt_amt;
    logic       nxt_fill;

    always #5 clk = ~clk;

    usr_shift_sequencer #(.N(N), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_dir     (in_dir),
        .in_amt     (in_amt),
        .in_fill    (in_fill),
        .usr_q      (usr_q),
        .usr_s      (usr_s),
        .usr_i      (usr_i),
        .usr_msb_in (usr_msb_in),
        .usr_lsb_in (usr_lsb_in),
        .out_bit    (out_bit),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    // Downstream universal shift register
    always_ff @(posedge clk) begin
        if (reset) usr_q <= '0;
        else begin
            case (usr_s)
                2'b01: usr_q <= {usr_msb_in, usr_q[3:1]};
                2'b10: usr_q <= {usr_q[2:0], usr_lsb_in};
                2'b11: usr_q <= usr_i;
                default: usr_q <= usr_q;
            endcase
        end
    end

    function automatic int clamp_amt(input logic [2:0] amt);
        return (amt > 3'd4) ? 4 : int'(amt);
    endfunction

    // k-th bit leaving the register: right shifts drop bit 0 first, left bit 3.
    function automatic logic ref_out(input logic [3:0] d, input logic dir, input int k);
        logic [3:0] t;
        t = dir ? (d >> (3 - k)) : (d >> k);
        return t[0];
    endfunction

    function automatic logic [3:0] ref_final(input logic [3:0] d, input logic dir,
                                             input int a, input logic fill);
        logic [3:0] ones;
        if (dir) begin
            ones = 4'hF << a;
            return (d << a) | (fill ? ~ones : 4'h0);
        end else begin
            ones = 4'hF >> a;
            return (d >> a) | (fill ? ~ones : 4'h0);
        end
    endfunction

    task automatic accept(input logic [3:0] d, input logic dir, input logic [2:0] amt,
                          input logic fill);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_ready got=%b want=1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        in_amt   = amt;
        in_fill  = fill;
    endtask

    // Follows an accepted job through LOAD/SHIFT/DONE and the following IDLE.
    task automatic follow(input logic [3:0] d, input logic dir, input logic [2:0] amt,
                          input logic fill, input bit keep_valid);
        int a;
        logic [8:0] got;
        logic [8:0] want;
        logic [1:0] ws;
        logic       wov;
        logic [3:0] fq;
        a = clamp_amt(amt);
        for (int c = 1; c <= a + 2; c++) begin
            @(negedge clk);
            wov = (c >= 2) && (c <= a + 1);
            ws  = (c == 1) ? 2'b11 : (wov ? (dir ? 2'b10 : 2'b01) : 2'b00);
            want = {ws, wov, wov ? ref_out(d, dir, c - 2) : 1'b0, 1'b1, (c == a + 2),
                    1'b0, fill & ~dir, fill & dir};
            got  = {usr_s, out_valid, out_bit, busy, done, in_ready, usr_msb_in, usr_lsb_in};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL job_cycle%0d s/ov/ob/busy/done/rdy/msb/lsb got=%b want=%b",
                         c, got, want);
            end
            checks++;
            if (usr_i !== d) begin
                errors++;
                $display("FAIL job_cycle%0d usr_i got=%b want=%b", c, usr_i, d);
            end
            in_valid = keep_valid;
            if (keep_valid && c == a + 2) begin
                in_data = nxt_d; in_dir = nxt_dir; in_amt = nxt_amt; in_fill = nxt_fill;
            end else begin
                in_data = 4'($urandom); in_dir = 1'($urandom);
                in_amt  = 3'($urandom); in_fill = 1'($urandom);
            end
        end
        @(negedge clk);
        checks++;
        if ({usr_s, busy, done, in_ready, out_valid} !== 6'b000010) begin
            errors++;
            $display("FAIL job_idle s/busy/done/rdy/ov got=%b want=000010",
                     {usr_s, busy, done, in_ready, out_valid});
        end
        fq = ref_final(d, dir, a, fill);
        checks++;
        if (usr_q !== fq) begin
            errors++;
            $display("FAIL job_final_q got=%b want=%b", usr_q, fq);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0;
        in_data = '0; in_dir = 1'b0; in_amt = '0; in_fill = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_low got=%b want=0", in_ready);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({usr_s, usr_i, usr_msb_in, usr_lsb_in, out_bit, out_valid, busy, done, in_ready}
            !== 13'b00_0000_0000001) begin
            errors++;
            $display("FAIL reset_values got=%b want=0000000000001",
                     {usr_s, usr_i, usr_msb_in, usr_lsb_in, out_bit, out_valid, busy, done,
                      in_ready});
        end
        accept(4'b1010, 1'b0, 3'd4, 1'b1);
        @(negedge clk); in_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({usr_s, done, in_ready} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_midjob_cycle%0d s/done/rdy got=%b want=0000", i,
                         {usr_s, done, in_ready});
            end
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({usr_s, busy, done, in_ready} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_release s/busy/done/rdy got=%b want=00001",
                     {usr_s, busy, done, in_ready});
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({done, busy} !== 2'b00) begin
                errors++;
                $display("FAIL reset_no_done cycle%0d done/busy got=%b want=00", i, {done, busy});
            end
        end
    endtask

    task automatic test_right_shift();
        accept(4'b1011, 1'b0, 3'd4, 1'b0);
        follow(4'b1011, 1'b0, 3'd4, 1'b0, 1'b0);
    endtask

    task automatic test_left_shift();
        accept(4'b1001, 1'b1, 3'd2, 1'b1);
        follow(4'b1001, 1'b1, 3'd2, 1'b1, 1'b0);
    endtask

    task automatic test_zero_and_clamp();
        accept(4'b0110, 1'b0, 3'd0, 1'b1);
        follow(4'b0110, 1'b0, 3'd0, 1'b1, 1'b0);
        accept(4'b1100, 1'b1, 3'd7, 1'b1);
        follow(4'b1100, 1'b1, 3'd7, 1'b1, 1'b0);
        accept(4'b0101, 1'b0, 3'd5, 1'b0);
        follow(4'b0101, 1'b0, 3'd5, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [3:0] d;
        logic       dir;
        logic [2:0] amt;
        logic       fill;
        for (int j = 0; j < 3; j++) begin
            d = 4'($urandom); dir = 1'($urandom); amt = 3'($urandom); fill = 1'($urandom);
            nxt_d = 4'($urandom); nxt_dir = 1'($urandom);
            nxt_amt = 3'($urandom); nxt_fill = 1'($urandom);
            accept(d, dir, amt, fill);
            follow(d, dir, amt, fill, 1'b1);
            follow(nxt_d, nxt_dir, nxt_amt, nxt_fill, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [3:0] d;
        logic       dir;
        logic [2:0] amt;
        logic       fill;
        for (int j = 0; j < 20; j++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            d = 4'($urandom); dir = 1'($urandom); amt = 3'($urandom); fill = 1'($urandom);
            accept(d, dir, amt, fill);
            follow(d, dir, amt, fill, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_right_shift();
        test_left_shift();
        test_zero_and_clamp();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
